// File: rtl/dbus_access_ctrl.sv
// Memory-stage data-bus sequencer: one outstanding access at a time.
// Aligns store data/strobe, extends load data and stalls MEM until done.
module dbus_access_ctrl #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic [3:0]        req_type,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              stall,
    output logic              resp_valid,
    output logic              resp_err,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              dreq_valid,
    output logic [ADDR_W-1:0] dreq_addr,
    output logic [1:0]        dreq_size,
    output logic [3:0]        dreq_strobe,
    output logic [DATA_W-1:0] dreq_data,
    input  logic              dresp_addr_ok,
    input  logic              dresp_data_ok,
    input  logic [DATA_W-1:0] dresp_data
);

    localparam logic [3:0] T_LB  = 4'd1;
    localparam logic [3:0] T_LBU = 4'd2;
    localparam logic [3:0] T_LH  = 4'd3;
    localparam logic [3:0] T_LHU = 4'd4;
    localparam logic [3:0] T_LW  = 4'd5;
    localparam logic [3:0] T_SB  = 4'd6;
    localparam logic [3:0] T_SH  = 4'd7;
    localparam logic [3:0] T_SW  = 4'd8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [3:0]        type_q, type_d;
    logic              dreq_valid_q, dreq_valid_d;
    logic [ADDR_W-1:0] dreq_addr_q, dreq_addr_d;
    logic [1:0]        dreq_size_q, dreq_size_d;
    logic [3:0]        dreq_strobe_q, dreq_strobe_d;
    logic [DATA_W-1:0] dreq_data_q, dreq_data_d;
    logic              resp_valid_q, resp_valid_d;
    logic              resp_err_q, resp_err_d;
    logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;

    logic              acc, misal;
    logic              is_byte, is_half, is_word, is_store;
    logic [4:0]        st_shamt, ld_shamt;
    logic [1:0]        al_size;
    logic [3:0]        al_strobe;
    logic [DATA_W-1:0] al_data;
    logic [DATA_W-1:0] ld_raw, ld_data;

    // Request decode and store alignment for the incoming instruction
    always_comb begin
        is_byte  = 1'b0;
        is_half  = 1'b0;
        is_word  = 1'b0;
        is_store = 1'b0;
        case (req_type)
            T_LB, T_LBU: is_byte = 1'b1;
            T_LH, T_LHU: is_half = 1'b1;
            T_LW:        is_word = 1'b1;
            T_SB: begin
                is_byte  = 1'b1;
                is_store = 1'b1;
            end
            T_SH: begin
                is_half  = 1'b1;
                is_store = 1'b1;
            end
            T_SW: begin
                is_word  = 1'b1;
                is_store = 1'b1;
            end
            default: ;
        endcase
    end

    assign acc   = req_valid & (is_byte | is_half | is_word);
    assign misal = (is_half & req_addr[0])
                 | (is_word & (req_addr[1:0] != 2'b00));

    assign st_shamt = {req_addr[1:0], 3'b000};
    assign al_size  = is_byte ? 2'd0 : (is_half ? 2'd1 : 2'd2);

    always_comb begin
        al_data   = '0;
        al_strobe = 4'b0000;
        if (is_store) begin
            al_data = req_wdata << st_shamt;
            if (is_byte)
                al_strobe = 4'b0001 << req_addr[1:0];
            else if (is_half)
                al_strobe = 4'b0011 << {req_addr[1], 1'b0};
            else
                al_strobe = 4'b1111;
        end
    end

    // Load extraction uses the captured type and byte offset
    assign ld_shamt = {dreq_addr_q[1:0], 3'b000};
    assign ld_raw   = dresp_data >> ld_shamt;

    always_comb begin
        ld_data = '0;
        case (type_q)
            T_LB:  ld_data = {{(DATA_W-8){ld_raw[7]}}, ld_raw[7:0]};
            T_LBU: ld_data = {{(DATA_W-8){1'b0}}, ld_raw[7:0]};
            T_LH:  ld_data = {{(DATA_W-16){ld_raw[15]}}, ld_raw[15:0]};
            T_LHU: ld_data = {{(DATA_W-16){1'b0}}, ld_raw[15:0]};
            T_LW:  ld_data = ld_raw;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            type_q        <= '0;
            dreq_valid_q  <= 1'b0;
            dreq_addr_q   <= '0;
            dreq_size_q   <= '0;
            dreq_strobe_q <= '0;
            dreq_data_q   <= '0;
            resp_valid_q  <= 1'b0;
            resp_err_q    <= 1'b0;
            resp_rdata_q  <= '0;
        end else begin
            state_q       <= state_d;
            type_q        <= type_d;
            dreq_valid_q  <= dreq_valid_d;
            dreq_addr_q   <= dreq_addr_d;
            dreq_size_q   <= dreq_size_d;
            dreq_strobe_q <= dreq_strobe_d;
            dreq_data_q   <= dreq_data_d;
            resp_valid_q  <= resp_valid_d;
            resp_err_q    <= resp_err_d;
            resp_rdata_q  <= resp_rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (acc) state_d = misal ? S_DONE : S_REQ;
            S_REQ: begin
                if (dresp_addr_ok)
                    state_d = dresp_data_ok ? S_DONE : S_WAIT;
            end
            S_WAIT: if (dresp_data_ok) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Registered outputs are computed for the state being entered
    always_comb begin
        type_d        = type_q;
        dreq_valid_d  = 1'b0;
        dreq_addr_d   = dreq_addr_q;
        dreq_size_d   = dreq_size_q;
        dreq_strobe_d = dreq_strobe_q;
        dreq_data_d   = dreq_data_q;
        resp_valid_d  = 1'b0;
        resp_err_d    = 1'b0;
        resp_rdata_d  = '0;
        case (state_q)
            S_IDLE: begin
                if (acc && misal) begin
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b1;
                end else if (acc) begin
                    type_d        = req_type;
                    dreq_valid_d  = 1'b1;
                    dreq_addr_d   = req_addr;
                    dreq_size_d   = al_size;
                    dreq_strobe_d = al_strobe;
                    dreq_data_d   = al_data;
                end
            end
            S_REQ: begin
                if (dresp_addr_ok && dresp_data_ok) begin
                    resp_valid_d = 1'b1;
                    resp_rdata_d = ld_data;
                end else if (!dresp_addr_ok) begin
                    dreq_valid_d = 1'b1;
                end
            end
            S_WAIT: begin
                if (dresp_data_ok) begin
                    resp_valid_d = 1'b1;
                    resp_rdata_d = ld_data;
                end
            end
            default: ;
        endcase
    end

    assign stall       = acc & (state_q != S_DONE);
    assign resp_valid  = resp_valid_q;
    assign resp_err    = resp_err_q;
    assign resp_rdata  = resp_rdata_q;
    assign dreq_valid  = dreq_valid_q;
    assign dreq_addr   = dreq_addr_q;
    assign dreq_size   = dreq_size_q;
    assign dreq_strobe = dreq_strobe_q;
    assign dreq_data   = dreq_data_q;

endmodule

// File: tb/tb_dbus_access_ctrl.sv
// Scoreboard bench for dbus_access_ctrl: directed cases plus random traffic
// against a byte-lane reference model, with a reactive data-bus responder.
`timescale 1ns/1ps
module tb_dbus_access_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic [3:0]  req_type;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic        dreq_valid;
    logic [31:0] dreq_addr;
    logic [1:0]  dreq_size;
    logic [3:0]  dreq_strobe;
    logic [31:0] dreq_data;
    logic        dresp_addr_ok;
    logic        dresp_data_ok;
    logic [31:0] dresp_data;

    always #5 clk = ~clk;

    dbus_access_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_type(req_type),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .stall(stall), .resp_valid(resp_valid),
        .resp_err(resp_err), .resp_rdata(resp_rdata),
        .dreq_valid(dreq_valid), .dreq_addr(dreq_addr),
        .dreq_size(dreq_size), .dreq_strobe(dreq_strobe),
        .dreq_data(dreq_data), .dresp_addr_ok(dresp_addr_ok),
        .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data)
    );

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  size;
        logic [3:0]  strobe;
        logic [31:0] data;
    } req_t;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
    } rsp_t;

    req_t exp_req_q[$];
    rsp_t exp_rsp_q[$];
    req_t cur_req;
    rsp_t cur_rsp;
    bit   prev_dv;
    int   n_chk = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Reference model: access width in bytes per type
    function automatic int nbytes(input int t);
        case (t)
            1, 2, 6: return 1;
            3, 4, 7: return 2;
            5, 8:    return 4;
            default: return 0;
        endcase
    endfunction

    function automatic logic [31:0] load_val(input int t, input int k,
                                             input logic [31:0] rd);
        int     nb;
        longint v;
        nb = nbytes(t);
        v = (longint'(rd) >> (8 * k)) & ((longint'(1) << (8 * nb)) - 1);
        if ((t == 1 || t == 3) && v >= (longint'(1) << (8 * nb - 1)))
            v = v - (longint'(1) << (8 * nb));
        return v[31:0];
    endfunction

    // Monitor: pops expectations whenever the DUT presents a request/response
    always @(negedge clk) begin
        if (reset) begin
            prev_dv = 1'b0;
        end else begin
            if (resp_valid) begin
                if (exp_rsp_q.size() == 0) begin
                    fail_now("resp_unexpected");
                end else begin
                    cur_rsp = exp_rsp_q.pop_front();
                    chk("resp_err", resp_err, cur_rsp.err);
                    chk("resp_rdata", resp_rdata, cur_rsp.rdata);
                end
            end
            if (dreq_valid) begin
                if (!prev_dv) begin
                    if (exp_req_q.size() == 0)
                        fail_now("dreq_unexpected");
                    else
                        cur_req = exp_req_q.pop_front();
                end
                chk("dreq_addr", dreq_addr, cur_req.addr);
                chk("dreq_size", dreq_size, cur_req.size);
                chk("dreq_strobe", dreq_strobe, cur_req.strobe);
                chk("dreq_data", dreq_data, cur_req.data);
            end
            prev_dv = dreq_valid;
        end
    end

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic txn(input int t, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] rd,
                       input int a_dly, input int d_dly, input bit noise);
        int   nb = nbytes(t);
        int   k = int'(addr[1:0]);
        bit   mis = (k % nb) != 0;
        int   cyc = 0;
        int   vcnt = 0;
        int   wcnt = 0;
        bit   accepted = 1'b0;
        bit   stall_ok = 1'b1;
        req_t rq;
        rsp_t rs;
        logic [31:0] sd;
        logic [31:0] sb;
        req_valid = 1'b1;
        req_type  = t[3:0];
        req_addr  = addr;
        req_wdata = wd;
        rs.err   = mis;
        rs.rdata = 32'h0;
        if (!mis) begin
            sd = wd << (8 * k);
            sb = ((32'h1 << nb) - 1) << k;
            rq.addr   = addr;
            rq.size   = (nb == 1) ? 2'd0 : ((nb == 2) ? 2'd1 : 2'd2);
            rq.strobe = (t >= 6) ? sb[3:0] : 4'b0000;
            rq.data   = (t >= 6) ? sd : 32'h0;
            exp_req_q.push_back(rq);
            if (t < 6) rs.rdata = load_val(t, k, rd);
        end
        exp_rsp_q.push_back(rs);
        while (1) begin
            if (cyc > 200) begin
                fail_now("txn_timeout");
                break;
            end
            @(negedge clk);
            dresp_addr_ok = 1'b0;
            dresp_data_ok = 1'b0;
            dresp_data    = $urandom;
            if (resp_valid) begin
                chk("stall_low_done", stall, 1'b0);
                break;
            end
            if (!stall) stall_ok = 1'b0;
            if (dreq_valid) begin
                vcnt++;
                if (vcnt > a_dly) begin
                    dresp_addr_ok = 1'b1;
                    if (d_dly == 0) begin
                        dresp_data_ok = 1'b1;
                        dresp_data    = rd;
                    end else begin
                        accepted = 1'b1;
                    end
                end else if (noise && $urandom_range(1) == 1) begin
                    dresp_data_ok = 1'b1;
                end
            end else if (accepted) begin
                wcnt++;
                if (wcnt >= d_dly) begin
                    dresp_data_ok = 1'b1;
                    dresp_data    = rd;
                end
            end
            next_cyc();
            cyc++;
        end
        chk("latency", cyc, mis ? 1 : 2 + a_dly + d_dly);
        chk("stall_high", stall_ok, 1'b1);
        chk("req_cycles", vcnt, mis ? 0 : a_dly + 1);
        chk("wait_cycles", wcnt, mis ? 0 : d_dly);
        next_cyc();
    endtask

    task automatic idle_cycle();
        int r = $urandom_range(7);
        req_valid = $urandom_range(1) == 1;
        req_type  = (r == 0) ? 4'd0 : 4'(8 + r);
        req_addr  = $urandom;
        req_wdata = $urandom;
        @(negedge clk);
        chk("idle_stall", stall, 1'b0);
        chk("idle_dreq", dreq_valid, 1'b0);
        next_cyc();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_stall"}, stall, 1'b0);
        chk({tag, "_resp_valid"}, resp_valid, 1'b0);
        chk({tag, "_resp_err"}, resp_err, 1'b0);
        chk({tag, "_resp_rdata"}, resp_rdata, 32'h0);
        chk({tag, "_dreq_valid"}, dreq_valid, 1'b0);
        chk({tag, "_dreq_addr"}, dreq_addr, 32'h0);
        chk({tag, "_dreq_size"}, dreq_size, 2'd0);
        chk({tag, "_dreq_strobe"}, dreq_strobe, 4'h0);
        chk({tag, "_dreq_data"}, dreq_data, 32'h0);
    endtask

    initial begin
        int   t;
        int   g;
        req_t rq;
        logic [31:0] a;
        reset         = 1'b1;
        req_valid     = 1'b0;
        req_type      = 4'd0;
        req_addr      = 32'h0;
        req_wdata     = 32'h0;
        dresp_addr_ok = 1'b0;
        dresp_data_ok = 1'b0;
        dresp_data    = 32'h0;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        next_cyc();
        reset = 1'b0;
        next_cyc();

        txn(8, 32'h100, 32'hDEADBEEF, 32'h0, 0, 0, 1'b0);
        txn(6, 32'h103, 32'h000000AB, 32'h0, 0, 0, 1'b0);
        txn(1, 32'h101, 32'h0, 32'h123480FF, 0, 0, 1'b0);
        txn(2, 32'h101, 32'h0, 32'h123480FF, 0, 0, 1'b0);
        txn(3, 32'h102, 32'h0, 32'h80010000, 2, 2, 1'b0);
        txn(5, 32'h102, 32'h0, 32'h0, 0, 0, 1'b0);

        // Reset while the request sits in the data phase
        req_valid = 1'b1;
        req_type  = 4'd5;
        req_addr  = 32'h200;
        req_wdata = $urandom;
        rq.addr   = 32'h200;
        rq.size   = 2'd2;
        rq.strobe = 4'h0;
        rq.data   = 32'h0;
        exp_req_q.push_back(rq);
        for (g = 0; g < 20; g++) begin
            @(negedge clk);
            if (dreq_valid) break;
            next_cyc();
        end
        if (!dreq_valid) fail_now("wait_setup_no_dreq");
        dresp_addr_ok = 1'b1;
        next_cyc();
        dresp_addr_ok = 1'b0;
        @(negedge clk);
        chk("wait_dreq_low", dreq_valid, 1'b0);
        chk("wait_no_resp", resp_valid, 1'b0);
        #1;
        reset     = 1'b1;
        req_valid = 1'b0;
        #1;
        chk_all_zero("midreset");
        @(posedge clk);
        next_cyc();
        reset = 1'b0;
        next_cyc();
        txn(8, 32'h300, 32'hCAFEF00D, 32'h0, 1, 1, 1'b0);

        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(3) == 0) begin
                idle_cycle();
            end else begin
                t = $urandom_range(8, 1);
                a = $urandom;
                txn(t, a, $urandom, $urandom, $urandom_range(3),
                    $urandom_range(3), $urandom_range(1) == 1);
            end
        end

        req_valid = 1'b0;
        repeat (3) next_cyc();
        chk("rsp_queue_empty", exp_rsp_q.size(), 0);
        chk("req_queue_empty", exp_req_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
